rx_axi_arbiter: RTL and testbench

Two-port AXI3 master arbiter for the receive path. It merges the descriptor iDMA external master (port 0) and the data iDMA external master (port 1) onto the single external bus master port.
- Write and read channels are arbitrated independently.
- A grant is held for one complete transaction: AW, all W beats and B for writes; AR and all R beats for reads.
- Sits between both iDMA ext_m ports and the rx path axi_m bus.

---
 rtl/rx_axi_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_rx_axi_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_axi_arbiter.sv
// rx_axi_arbiter: two-port AXI3 master arbiter with independent write/read FSMs, each grant held for a whole transaction.
// Build option: define RX_ARB_FIXED_PRIO_EN for fixed port-0 priority; otherwise round-robin.
module rx_axi_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [3:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ID_W-1:0]     s0_wid,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic [ID_W-1:0]     s0_bid,
  output logic [1:0]          s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  input  logic [ID_W-1:0]     s0_arid,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [3:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  output logic [ID_W-1:0]     s0_rid,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [3:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ID_W-1:0]     s1_wid,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic [ID_W-1:0]     s1_bid,
  output logic [1:0]          s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  input  logic [ID_W-1:0]     s1_arid,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [3:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  output logic [ID_W-1:0]     s1_rid,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_wid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t r_wstate, w_wstate_next;
  r_state_t r_rstate, w_rstate_next;
  logic     r_wgrant, w_wgrant_next;
  logic     r_rgrant, w_rgrant_next;
  logic     w_wpick, w_rpick;
  logic     w_b_done, w_r_done;

  assign w_b_done = (r_wstate == W_RESP) && m_bvalid && (r_wgrant ? s1_bready : s0_bready);
  assign w_r_done = (r_rstate == R_DATA) && m_rvalid && m_rlast && (r_rgrant ? s1_rready : s0_rready);

`ifdef RX_ARB_FIXED_PRIO_EN
  assign w_wpick = !s0_awvalid;
  assign w_rpick = !s0_arvalid;
`else
  logic r_w_last, r_r_last;

  // On a tie the port that did not win last time gets the bus.
  assign w_wpick = (s0_awvalid && s1_awvalid) ? ~r_w_last : s1_awvalid;
  assign w_rpick = (s0_arvalid && s1_arvalid) ? ~r_r_last : s1_arvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_w_last <= 1'b1;
      r_r_last <= 1'b1;
    end else begin
      if (w_b_done) r_w_last <= r_wgrant;
      if (w_r_done) r_r_last <= r_rgrant;
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wgrant <= 1'b0;
      r_rgrant <= 1'b0;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
      r_wgrant <= w_wgrant_next;
      r_rgrant <= w_rgrant_next;
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    w_wgrant_next = r_wgrant;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = 1'b0;
    m_wid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
    m_bready = 1'b0;
    s0_awready = 1'b0; s1_awready = 1'b0;
    s0_wready = 1'b0; s1_wready = 1'b0;
    s0_bid = '0; s0_bresp = '0; s0_bvalid = 1'b0;
    s1_bid = '0; s1_bresp = '0; s1_bvalid = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (s0_awvalid || s1_awvalid) begin
          w_wgrant_next = w_wpick;
          w_wstate_next = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awid     = r_wgrant ? s1_awid    : s0_awid;
        m_awaddr   = r_wgrant ? s1_awaddr  : s0_awaddr;
        m_awlen    = r_wgrant ? s1_awlen   : s0_awlen;
        m_awsize   = r_wgrant ? s1_awsize  : s0_awsize;
        m_awburst  = r_wgrant ? s1_awburst : s0_awburst;
        m_awvalid  = r_wgrant ? s1_awvalid : s0_awvalid;
        s0_awready = !r_wgrant && m_awready;
        s1_awready = r_wgrant && m_awready;
        if (m_awvalid && m_awready) w_wstate_next = W_DATA;
      end
      W_DATA: begin
        m_wid     = r_wgrant ? s1_wid    : s0_wid;
        m_wdata   = r_wgrant ? s1_wdata  : s0_wdata;
        m_wstrb   = r_wgrant ? s1_wstrb  : s0_wstrb;
        m_wlast   = r_wgrant ? s1_wlast  : s0_wlast;
        m_wvalid  = r_wgrant ? s1_wvalid : s0_wvalid;
        s0_wready = !r_wgrant && m_wready;
        s1_wready = r_wgrant && m_wready;
        // The burst ends on wlast alone; awlen is not cross-checked.
        if (m_wvalid && m_wready && m_wlast) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        m_bready = r_wgrant ? s1_bready : s0_bready;
        if (r_wgrant) begin
          s1_bid = m_bid; s1_bresp = m_bresp; s1_bvalid = m_bvalid;
        end else begin
          s0_bid = m_bid; s0_bresp = m_bresp; s0_bvalid = m_bvalid;
        end
        if (w_b_done) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    w_rgrant_next = r_rgrant;
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = 1'b0;
    m_rready = 1'b0;
    s0_arready = 1'b0; s1_arready = 1'b0;
    s0_rid = '0; s0_rdata = '0; s0_rresp = '0; s0_rlast = 1'b0; s0_rvalid = 1'b0;
    s1_rid = '0; s1_rdata = '0; s1_rresp = '0; s1_rlast = 1'b0; s1_rvalid = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          w_rgrant_next = w_rpick;
          w_rstate_next = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arid     = r_rgrant ? s1_arid    : s0_arid;
        m_araddr   = r_rgrant ? s1_araddr  : s0_araddr;
        m_arlen    = r_rgrant ? s1_arlen   : s0_arlen;
        m_arsize   = r_rgrant ? s1_arsize  : s0_arsize;
        m_arburst  = r_rgrant ? s1_arburst : s0_arburst;
        m_arvalid  = r_rgrant ? s1_arvalid : s0_arvalid;
        s0_arready = !r_rgrant && m_arready;
        s1_arready = r_rgrant && m_arready;
        if (m_arvalid && m_arready) w_rstate_next = R_DATA;
      end
      R_DATA: begin
        m_rready = r_rgrant ? s1_rready : s0_rready;
        if (r_rgrant) begin
          s1_rid = m_rid; s1_rdata = m_rdata; s1_rresp = m_rresp;
          s1_rlast = m_rlast; s1_rvalid = m_rvalid;
        end else begin
          s0_rid = m_rid; s0_rdata = m_rdata; s0_rresp = m_rresp;
          s0_rlast = m_rlast; s0_rvalid = m_rvalid;
        end
        if (w_r_done) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_axi_arbiter.sv
// Self-checking bench for rx_axi_arbiter: the bench plays both iDMA masters and the downstream slave.
module tb_rx_axi_arbiter;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [1:0][3:0]  awid;   logic [1:0][63:0] awaddr; logic [1:0][3:0] awlen;
  logic [1:0][2:0]  awsize; logic [1:0][1:0]  awburst;
  logic [1:0]       awvalid, awready;
  logic [1:0][3:0]  wid;    logic [1:0][31:0] wdata;  logic [1:0][3:0] wstrb;
  logic [1:0]       wlast, wvalid, wready;
  logic [1:0][3:0]  bid;    logic [1:0][1:0]  bresp;
  logic [1:0]       bvalid, bready;
  logic [1:0][3:0]  arid;   logic [1:0][63:0] araddr; logic [1:0][3:0] arlen;
  logic [1:0][2:0]  arsize; logic [1:0][1:0]  arburst;
  logic [1:0]       arvalid, arready;
  logic [1:0][3:0]  rid;    logic [1:0][31:0] rdata;  logic [1:0][1:0] rresp;
  logic [1:0]       rlast, rvalid, rready;

  logic [3:0]  m_awid, m_wid, m_arid, m_bid, m_rid;
  logic [63:0] m_awaddr, m_araddr;
  logic [3:0]  m_awlen, m_arlen, m_wstrb;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [31:0] m_wdata, m_rdata;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  logic [14:0] all_vr;
  assign all_vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                   awready, wready, bvalid, arready, rvalid};

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_w[$];
  logic [32:0] exp_r[$];

  rx_axi_arbiter #(.ADDR_W(64), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awid(awid[0]), .s0_awaddr(awaddr[0]), .s0_awlen(awlen[0]), .s0_awsize(awsize[0]),
    .s0_awburst(awburst[0]), .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
    .s0_wid(wid[0]), .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wlast(wlast[0]),
    .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
    .s0_bid(bid[0]), .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
    .s0_arid(arid[0]), .s0_araddr(araddr[0]), .s0_arlen(arlen[0]), .s0_arsize(arsize[0]),
    .s0_arburst(arburst[0]), .s0_arvalid(arvalid[0]), .s0_arready(arready[0]),
    .s0_rid(rid[0]), .s0_rdata(rdata[0]), .s0_rresp(rresp[0]), .s0_rlast(rlast[0]),
    .s0_rvalid(rvalid[0]), .s0_rready(rready[0]),
    .s1_awid(awid[1]), .s1_awaddr(awaddr[1]), .s1_awlen(awlen[1]), .s1_awsize(awsize[1]),
    .s1_awburst(awburst[1]), .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
    .s1_wid(wid[1]), .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wlast(wlast[1]),
    .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
    .s1_bid(bid[1]), .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
    .s1_arid(arid[1]), .s1_araddr(araddr[1]), .s1_arlen(arlen[1]), .s1_arsize(arsize[1]),
    .s1_arburst(arburst[1]), .s1_arvalid(arvalid[1]), .s1_arready(arready[1]),
    .s1_rid(rid[1]), .s1_rdata(rdata[1]), .s1_rresp(rresp[1]), .s1_rlast(rlast[1]),
    .s1_rvalid(rvalid[1]), .s1_rready(rready[1]),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_inputs();
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = '0; wvalid = '0; bready = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = '0; rready = '0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
    m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
  endtask

  task automatic req_aw(input int p, input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len);
    awid[p] = id; awaddr[p] = addr; awlen[p] = len; awsize[p] = 3'd2; awburst[p] = 2'b01;
    awvalid[p] = 1'b1;
  endtask

  task automatic req_ar(input int p, input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len);
    arid[p] = id; araddr[p] = addr; arlen[p] = len; arsize[p] = 3'd2; arburst[p] = 2'b01;
    arvalid[p] = 1'b1;
  endtask

  // Full write on port p: AW, nbeats of W, then B carrying resp. Expects port p to be granted.
  task automatic write_xfer(input int p, input logic [3:0] id, input logic [63:0] addr,
                            input int nbeats, input logic [1:0] resp, input bit toggle);
    bit done = 0;
    bit hs;
    int beat = 0;
    logic [32:0] e;
    m_awready = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge aclk);
      if (m_awvalid) begin
        n_tests++;
        if (m_awaddr !== addr || m_awid !== id || m_awlen !== 4'(nbeats - 1) ||
            m_awsize !== 3'd2 || m_awburst !== 2'b01) begin
          n_fail++;
          $display("FAIL aw_fwd p%0d: got addr=%h id=%h len=%0d, expected addr=%h id=%h len=%0d",
                   p, m_awaddr, m_awid, m_awlen, addr, id, nbeats - 1);
        end
        n_tests++;
        if (awready[p] !== 1'b1 || awready[1-p] !== 1'b0) begin
          n_fail++;
          $display("FAIL awready_route p%0d: got %b expected only port %0d", p, awready, p);
        end
        done = 1;
      end
      step();
    end
    awvalid[p] = 0;
    m_awready = 0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout p%0d: got no m_awvalid, expected a grant", p);
      return;
    end

    for (int b = 0; b < nbeats; b++) exp_w.push_back({(b == nbeats - 1), addr[15:0], 16'(b)});
    wid[p] = id; wstrb[p] = 4'hF; wvalid[p] = 1;
    wdata[p] = {addr[15:0], 16'(beat)}; wlast[p] = (nbeats == 1);
    wvalid[1-p] = 1; wdata[1-p] = 32'hDEAD_BEEF; wlast[1-p] = 1;
    m_wready = 1;
    for (int c = 0; c < 100 && exp_w.size() > 0; c++) begin
      @(negedge aclk);
      hs = 0;
      n_tests++;
      if (wready[p] !== m_wready || wready[1-p] !== 1'b0) begin
        n_fail++;
        $display("FAIL w_ready_route p%0d: got %b with m_wready=%b", p, wready, m_wready);
      end
      if (m_wvalid && m_wready) begin
        e = exp_w.pop_front();
        n_tests++;
        if ({m_wlast, m_wdata} !== e || m_wid !== id) begin
          n_fail++;
          $display("FAIL w_beat p%0d: got last=%b data=%h, expected last=%b data=%h",
                   p, m_wlast, m_wdata, e[32], e[31:0]);
        end
        hs = 1;
      end
      step();
      if (hs) begin
        beat++;
        if (beat < nbeats) begin
          wdata[p] = {addr[15:0], 16'(beat)};
          wlast[p] = (beat == nbeats - 1);
        end else begin
          wvalid[p] = 0;
          wlast[p] = 0;
        end
      end
      if (toggle) m_wready = ~m_wready;
    end
    wvalid = '0; wlast = '0; m_wready = 0;
    if (exp_w.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL w_timeout p%0d: got %0d beats outstanding, expected 0", p, exp_w.size());
      exp_w.delete();
      return;
    end

    m_bvalid = 1; m_bid = id; m_bresp = resp; bready = 2'b11;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge aclk);
      if (bvalid[p]) begin
        n_tests++;
        if (bid[p] !== id || bresp[p] !== resp || bvalid[1-p] !== 1'b0 || m_bready !== 1'b1) begin
          n_fail++;
          $display("FAIL b_route p%0d: got bid=%h bresp=%b bvalid=%b m_bready=%b, expected bid=%h bresp=%b",
                   p, bid[p], bresp[p], bvalid, m_bready, id, resp);
        end
        done = 1;
      end
      step();
    end
    m_bvalid = 0; bready = '0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout p%0d: got no bvalid, expected response", p);
    end
  endtask

  // Full read on port p; the slave returns nbeats with rlast on the final one.
  task automatic read_xfer(input int p, input logic [3:0] id, input logic [63:0] addr, input int nbeats);
    bit done = 0;
    bit hs;
    int beat = 0;
    logic [32:0] e;
    m_arready = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge aclk);
      if (m_arvalid) begin
        n_tests++;
        if (m_araddr !== addr || m_arid !== id || m_arlen !== 4'(nbeats - 1) ||
            arready[p] !== 1'b1 || arready[1-p] !== 1'b0) begin
          n_fail++;
          $display("FAIL ar_fwd p%0d: got addr=%h id=%h len=%0d arready=%b, expected addr=%h id=%h",
                   p, m_araddr, m_arid, m_arlen, arready, addr, id);
        end
        done = 1;
      end
      step();
    end
    arvalid[p] = 0;
    m_arready = 0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout p%0d: got no m_arvalid, expected a grant", p);
      return;
    end

    for (int b = 0; b < nbeats; b++) exp_r.push_back({(b == nbeats - 1), ~{addr[15:0], 16'(b)}});
    m_rvalid = 1; m_rid = id; m_rresp = 2'b00;
    m_rdata = ~{addr[15:0], 16'(beat)}; m_rlast = (nbeats == 1);
    rready = 2'b11;
    for (int c = 0; c < 100 && exp_r.size() > 0; c++) begin
      @(negedge aclk);
      hs = 0;
      n_tests++;
      if (rvalid[1-p] !== 1'b0) begin
        n_fail++;
        $display("FAIL r_other_quiet p%0d: got rvalid=%b, expected other port 0", p, rvalid);
      end
      if (m_rvalid && m_rready) begin
        e = exp_r.pop_front();
        n_tests++;
        if ({rlast[p], rdata[p]} !== e || rvalid[p] !== 1'b1 || rid[p] !== id) begin
          n_fail++;
          $display("FAIL r_beat p%0d: got last=%b data=%h valid=%b, expected last=%b data=%h",
                   p, rlast[p], rdata[p], rvalid[p], e[32], e[31:0]);
        end
        hs = 1;
      end
      step();
      if (hs) begin
        beat++;
        if (beat < nbeats) begin
          m_rdata = ~{addr[15:0], 16'(beat)};
          m_rlast = (beat == nbeats - 1);
        end else begin
          m_rvalid = 0;
          m_rlast = 0;
        end
      end
    end
    if (exp_r.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL r_timeout p%0d: got %0d beats outstanding, expected 0", p, exp_r.size());
      exp_r.delete();
      m_rvalid = 0; rready = '0;
      return;
    end
    @(negedge aclk);
    n_tests++;
    if (m_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL r_idle_after_last p%0d: got m_rready=%b, expected 0", p, m_rready);
    end
    step();
    rready = '0;
  endtask

  task automatic test_reset();
    clr_inputs();
    aresetn = 0;
    awvalid = 2'b11; wvalid = 2'b11; bready = 2'b11; arvalid = 2'b11; rready = 2'b11;
    awaddr[0] = 64'h1234; m_awready = 1; m_wready = 1; m_bvalid = 1; m_arready = 1; m_rvalid = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_tests++;
    if (all_vr !== '0 || m_awaddr !== '0 || m_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vr=%b awaddr=%h, expected all 0", all_vr, m_awaddr);
    end
    clr_inputs();
    aresetn = 1;
    step();
    @(negedge aclk);
    n_tests++;
    if (all_vr !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got vr=%b, expected all 0", all_vr);
    end
    step();
  endtask

  task automatic test_write_rr();
    req_aw(0, 4'h3, 64'h0000_0000_0000_A000, 4'd3);
    req_aw(1, 4'h5, 64'h0000_0000_0000_B000, 4'd3);
    @(negedge aclk);
    n_tests++;
    if (m_awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_latency: got m_awvalid=%b, expected 0 in arbitration cycle", m_awvalid);
    end
    step();
    write_xfer(0, 4'h3, 64'h0000_0000_0000_A000, 4, 2'b00, 0);
    req_aw(0, 4'h6, 64'h0000_0000_0000_C000, 4'd3);
    write_xfer(1, 4'h5, 64'h0000_0000_0000_B000, 4, 2'b10, 0);
    write_xfer(0, 4'h6, 64'h0000_0000_0000_C000, 4, 2'b00, 1);
  endtask

  task automatic test_read();
    req_ar(1, 4'h9, 64'h0000_0000_0000_1000, 4'd15);
    read_xfer(1, 4'h9, 64'h0000_0000_0000_1000, 16);
  endtask

  task automatic test_concurrent();
    req_aw(0, 4'h2, 64'h0000_0000_0000_E000, 4'd1);
    req_ar(1, 4'h7, 64'h0000_0000_0000_2000, 4'd3);
    @(negedge aclk);
    step();
    @(negedge aclk);
    n_tests++;
    if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL concurrent_grant: got awvalid=%b arvalid=%b, expected both 1", m_awvalid, m_arvalid);
    end
    step();
    fork
      write_xfer(0, 4'h2, 64'h0000_0000_0000_E000, 2, 2'b00, 0);
      read_xfer(1, 4'h7, 64'h0000_0000_0000_2000, 4);
    join
  endtask

  task automatic test_reset_mid();
    bit done = 0;
    req_aw(1, 4'hA, 64'h0000_0000_0000_D000, 4'd3);
    m_awready = 1;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge aclk);
      done = m_awvalid;
      step();
    end
    awvalid = '0; m_awready = 0;
    wid[1] = 4'hA; wdata[1] = 32'h5555_0000; wstrb[1] = 4'hF; wvalid[1] = 1; m_wready = 1;
    @(negedge aclk);
    n_tests++;
    if (m_wvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wdata: got m_wvalid=%b, expected 1 before reset", m_wvalid);
    end
    aresetn = 0;
    #1;
    n_tests++;
    if (all_vr !== '0 || m_wdata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got vr=%b wdata=%h, expected all 0", all_vr, m_wdata);
    end
    clr_inputs();
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    step();
    req_aw(0, 4'h1, 64'h0000_0000_0000_F000, 4'd0);
    req_aw(1, 4'h4, 64'h0000_0000_0000_9000, 4'd0);
    write_xfer(0, 4'h1, 64'h0000_0000_0000_F000, 1, 2'b00, 0);
    write_xfer(1, 4'h4, 64'h0000_0000_0000_9000, 1, 2'b11, 0);
  endtask

  initial begin
    test_reset();
    test_write_rr();
    test_read();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
